// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter that feeds one command at a time from NREQ requesters into
// an APB master. It routes the response, or a timeout error, back to the requester that was granted.
module apb_cmd_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int CMD_WIDTH  = DATA_WIDTH + ADDR_WIDTH + 1,
   parameter int NREQ       = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ*CMD_WIDTH-1:0] req_cmd,
   input  logic [NREQ-1:0]           req_vld,
   output logic [NREQ-1:0]           req_rdy,
   output logic [NREQ-1:0]           rsp_vld,
   output logic [DATA_WIDTH-1:0]     rsp_data,
   output logic                      rsp_err,
   output logic [CMD_WIDTH-1:0]      m_cmd,
   output logic                      m_cmd_vld,
   input  logic                      m_cmd_rdy,
   input  logic                      m_rsp_vld,
   input  logic [DATA_WIDTH-1:0]     m_rsp_data,
   input  logic                      m_rsp_err,
   output logic                      busy,
   output logic [2:0]                grant_id,
   output logic                      timeout_flag
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

   state_e                  state_q;
   logic [2:0]              rr_ptr_q, grant_id_q;
   logic [CMD_WIDTH-1:0]    m_cmd_q;
   logic                    m_cmd_vld_q, busy_q, rsp_err_q, timeout_flag_q;
   logic [NREQ-1:0]         rsp_vld_q;
   logic [DATA_WIDTH-1:0]   rsp_data_q;
   logic [15:0]             cnt_q;

   logic [2*NREQ-1:0]       dbl_d;
   logic [NREQ-1:0]         rot_d, rsp_onehot_d;
   logic [3:0]              sum_d;
   logic                    found_d, tmo_d;
   logic [2:0]              win_d, rr_next_d;
   logic [CMD_WIDTH-1:0]    win_cmd_d;

   // Rotate the valids so that bit 0 is rr_ptr. The first set bit is then the round-robin winner.
   always_comb begin
      dbl_d   = {req_vld, req_vld} >> rr_ptr_q;
      rot_d   = dbl_d[NREQ-1:0];
      found_d = 1'b0;
      win_d   = '0;
      sum_d   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found_d && rot_d[k]) begin
            found_d = 1'b1;
            sum_d   = 4'(rr_ptr_q) + 4'(k);
            win_d   = (sum_d >= 4'(NREQ)) ? 3'(sum_d - 4'(NREQ)) : 3'(sum_d);
         end
      end
   end

   always_comb begin
      win_cmd_d    = '0;
      req_rdy      = '0;
      rsp_onehot_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_d == 3'(i)) win_cmd_d = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
         req_rdy[i]      = (state_q == S_IDLE) && !rst && found_d && (win_d == 3'(i));
         rsp_onehot_d[i] = (grant_id_q == 3'(i));
      end
   end

   assign rr_next_d = (grant_id_q == 3'(NREQ-1)) ? 3'd0 : grant_id_q + 3'd1;
   assign tmo_d     = (cnt_q == 16'(TIMEOUT-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         rr_ptr_q       <= '0;
         grant_id_q     <= '0;
         m_cmd_q        <= '0;
         m_cmd_vld_q    <= 1'b0;
         rsp_vld_q      <= '0;
         rsp_data_q     <= '0;
         rsp_err_q      <= 1'b0;
         busy_q         <= 1'b0;
         timeout_flag_q <= 1'b0;
         cnt_q          <= '0;
      end else begin
         rsp_vld_q <= '0;
         case (state_q)
            S_IDLE: if (found_d) begin
               state_q     <= S_ISSUE;
               m_cmd_q     <= win_cmd_d;
               grant_id_q  <= win_d;
               m_cmd_vld_q <= 1'b1;
               busy_q      <= 1'b1;
               cnt_q       <= '0;
            end
            S_ISSUE: begin
               cnt_q <= cnt_q + 16'd1;
               if (tmo_d) begin
                  state_q        <= S_IDLE;
                  m_cmd_vld_q    <= 1'b0;
                  busy_q         <= 1'b0;
                  rsp_vld_q      <= rsp_onehot_d;
                  rsp_data_q     <= '0;
                  rsp_err_q      <= 1'b1;
                  timeout_flag_q <= 1'b1;
                  rr_ptr_q       <= rr_next_d;
               end else if (m_cmd_rdy) begin
                  state_q     <= S_WAIT;
                  m_cmd_vld_q <= 1'b0;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + 16'd1;
               // A real response beats a timeout that lands in the same cycle.
               if (m_rsp_vld || tmo_d) begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  rsp_vld_q <= rsp_onehot_d;
                  rr_ptr_q  <= rr_next_d;
                  if (m_rsp_vld) begin
                     rsp_data_q <= m_cmd_q[CMD_WIDTH-1] ? '0 : m_rsp_data;
                     rsp_err_q  <= m_rsp_err;
                  end else begin
                     rsp_data_q     <= '0;
                     rsp_err_q      <= 1'b1;
                     timeout_flag_q <= 1'b1;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_vld      = rsp_vld_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_err      = rsp_err_q;
   assign m_cmd        = m_cmd_q;
   assign m_cmd_vld    = m_cmd_vld_q;
   assign busy         = busy_q;
   assign grant_id     = grant_id_q;
   assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Directed bench for apb_cmd_arbiter (NREQ=4, TIMEOUT=8).
// Expected values below were worked out by hand from the cycle behaviour.
module tb_apb_cmd_arbiter;
   localparam int DW = 32, AW = 12, CW = DW + AW + 1, NR = 4, TO = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*CW-1:0]  req_cmd;
   logic [NR-1:0]     req_vld, req_rdy, rsp_vld;
   logic [DW-1:0]     rsp_data, m_rsp_data;
   logic              rsp_err, m_cmd_vld, m_cmd_rdy, m_rsp_vld, m_rsp_err, busy, timeout_flag;
   logic [CW-1:0]     m_cmd;
   logic [2:0]        grant_id;

   int checks = 0;
   int failures = 0;

   apb_cmd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NREQ(NR), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_cmd(req_cmd), .req_vld(req_vld), .req_rdy(req_rdy),
      .rsp_vld(rsp_vld), .rsp_data(rsp_data), .rsp_err(rsp_err), .m_cmd(m_cmd),
      .m_cmd_vld(m_cmd_vld), .m_cmd_rdy(m_cmd_rdy), .m_rsp_vld(m_rsp_vld),
      .m_rsp_data(m_rsp_data), .m_rsp_err(m_rsp_err), .busy(busy),
      .grant_id(grant_id), .timeout_flag(timeout_flag));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] mkcmd(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      return {rw, a, d};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [CW-1:0] c;
   logic [3:0]    oh;

   initial begin
      req_cmd = '0; req_vld = '0; m_cmd_rdy = 0; m_rsp_vld = 0; m_rsp_data = '0; m_rsp_err = 0;
      // Reset state, with requests pending so that req_rdy is shown to stay low during reset
      rst = 1'b1;
      req_vld = 4'hF;
      tick();
      tick();
      chk("rst_req_rdy", 64'(req_rdy), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_m_cmd_vld", 64'(m_cmd_vld), 64'h0);
      chk("rst_m_cmd", 64'(m_cmd), 64'h0);
      chk("rst_rsp_vld", 64'(rsp_vld), 64'h0);
      chk("rst_rsp_data", 64'(rsp_data), 64'h0);
      chk("rst_grant", 64'(grant_id), 64'h0);
      chk("rst_tflag", 64'(timeout_flag), 64'h0);
      req_vld = '0;
      rst = 1'b0;

      // Single read from requester 2
      c = mkcmd(1'b0, 12'h010, 32'h0);
      req_cmd[2*CW +: CW] = c;
      req_vld = 4'b0100;
      #1 chk("rd_req_rdy", 64'(req_rdy), 64'h4);
      tick();
      req_vld = '0;
      chk("rd_m_cmd_vld", 64'(m_cmd_vld), 64'h1);
      chk("rd_m_cmd", 64'(m_cmd), 64'(c));
      chk("rd_grant", 64'(grant_id), 64'h2);
      chk("rd_busy", 64'(busy), 64'h1);
      m_cmd_rdy = 1;
      tick();
      m_cmd_rdy = 0;
      chk("rd_m_cmd_vld_drop", 64'(m_cmd_vld), 64'h0);
      m_rsp_vld = 1;
      m_rsp_data = 32'hDEADBEEF;
      tick();
      m_rsp_vld = 0;
      chk("rd_rsp_vld", 64'(rsp_vld), 64'h4);
      chk("rd_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
      chk("rd_rsp_err", 64'(rsp_err), 64'h0);
      chk("rd_busy_done", 64'(busy), 64'h0);
      m_rsp_data = 32'h0;
      tick();
      chk("rd_rsp_pulse", 64'(rsp_vld), 64'h0);
      chk("rd_rsp_hold", 64'(rsp_data), 64'hDEADBEEF);

      // Fairness from reset: odd requesters issue writes, so their rsp_data must be 0
      do_reset();
      for (int i = 0; i < NR; i++) req_cmd[i*CW +: CW] = mkcmd(i[0], 12'(i), 32'(i * 16 + 1));
      req_vld = 4'hF;
      for (int n = 0; n < 8; n++) begin
         oh = 4'b0001 << (n % 4);
         #1 chk($sformatf("fair_req_rdy%0d", n), 64'(req_rdy), 64'(oh));
         tick();
         chk($sformatf("fair_grant%0d", n), 64'(grant_id), 64'(n % 4));
         m_cmd_rdy = 1;
         tick();
         m_cmd_rdy = 0;
         m_rsp_vld = 1;
         m_rsp_data = 32'hA000_0000 + 32'(n);
         tick();
         m_rsp_vld = 0;
         chk($sformatf("fair_rsp_vld%0d", n), 64'(rsp_vld), 64'(oh));
         chk($sformatf("fair_rsp_data%0d", n), 64'(rsp_data),
             (n % 2 == 1) ? 64'h0 : 64'(32'hA000_0000 + 32'(n)));
      end
      req_vld = '0;

      // Backpressure on requester 1. A stray m_rsp_vld in ISSUE must be ignored.
      c = mkcmd(1'b0, 12'h111, 32'h0);
      req_cmd[1*CW +: CW] = c;
      req_vld = 4'b0010;
      tick();
      req_vld = 4'b0011;
      m_rsp_vld = 1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_vld%0d", k), 64'(m_cmd_vld), 64'h1);
         chk($sformatf("bp_cmd%0d", k), 64'(m_cmd), 64'(c));
         chk($sformatf("bp_req_rdy%0d", k), 64'(req_rdy), 64'h0);
         chk($sformatf("bp_no_rsp%0d", k), 64'(rsp_vld), 64'h0);
         tick();
      end
      m_rsp_vld = 0;
      req_vld = '0;
      m_cmd_rdy = 1;
      tick();
      m_cmd_rdy = 0;
      m_rsp_vld = 1;
      m_rsp_data = 32'h55;
      tick();
      m_rsp_vld = 0;
      chk("bp_rsp_vld", 64'(rsp_vld), 64'h2);
      chk("bp_rsp_data", 64'(rsp_data), 64'h55);

      // Timeout: rr_ptr is now 2, so requester 2 wins. Nothing responds.
      req_cmd[2*CW +: CW] = mkcmd(1'b0, 12'h222, 32'h0);
      req_vld = 4'b0100;
      tick();
      req_vld = '0;
      m_cmd_rdy = 1;
      for (int k = 1; k < TO; k++) begin
         chk($sformatf("to_quiet%0d", k), 64'(rsp_vld), 64'h0);
         tick();
         m_cmd_rdy = 0;
      end
      chk("to_quiet_last", 64'(rsp_vld), 64'h0);
      tick();
      chk("to_rsp_vld", 64'(rsp_vld), 64'h4);
      chk("to_rsp_err", 64'(rsp_err), 64'h1);
      chk("to_rsp_data", 64'(rsp_data), 64'h0);
      chk("to_flag", 64'(timeout_flag), 64'h1);
      chk("to_busy", 64'(busy), 64'h0);
      tick();
      chk("to_flag_sticky", 64'(timeout_flag), 64'h1);
      chk("to_err_hold", 64'(rsp_err), 64'h1);

      // Collision: the response arrives in exactly the timeout cycle
      do_reset();
      chk("col_flag_rst", 64'(timeout_flag), 64'h0);
      req_cmd[0 +: CW] = mkcmd(1'b0, 12'h000, 32'h0);
      req_vld = 4'b0001;
      tick();
      req_vld = '0;
      m_cmd_rdy = 1;
      tick();
      m_cmd_rdy = 0;
      for (int k = 0; k < TO - 2; k++) tick();
      m_rsp_vld = 1;
      m_rsp_data = 32'h12345678;
      tick();
      m_rsp_vld = 0;
      chk("col_rsp_vld", 64'(rsp_vld), 64'h1);
      chk("col_rsp_data", 64'(rsp_data), 64'h12345678);
      chk("col_rsp_err", 64'(rsp_err), 64'h0);
      chk("col_flag", 64'(timeout_flag), 64'h0);

      // Reset while in WAIT: the transaction is abandoned and rr_ptr goes back to 0
      req_vld = 4'b0100;
      tick();
      req_vld = '0;
      m_cmd_rdy = 1;
      tick();
      m_cmd_rdy = 0;
      rst = 1;
      m_rsp_vld = 1;
      tick();
      chk("rw_busy", 64'(busy), 64'h0);
      chk("rw_rsp_vld", 64'(rsp_vld), 64'h0);
      chk("rw_grant", 64'(grant_id), 64'h0);
      rst = 0;
      m_rsp_vld = 0;
      tick();
      chk("rw_rsp_vld_after", 64'(rsp_vld), 64'h0);
      req_vld = 4'b1011;
      #1 chk("rw_req_rdy", 64'(req_rdy), 64'h1);
      tick();
      chk("rw_grant_next", 64'(grant_id), 64'h0);
      req_vld = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
